// File: rtl/mdio_pkg.sv
// Shared constants and state encoding for the Clause-22 MDIO responder.
package mdio_pkg;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  localparam logic [4:0] REG_PHYID1 = 5'h02;
  localparam logic [4:0] REG_PHYID2 = 5'h03;
  localparam logic [4:0] REG_LEDCR  = 5'h18;

  typedef enum logic [3:0] {
    HUNT,
    START,
    OP,
    PHYAD,
    REGAD,
    TA,
    RD_DATA,
    WR_DATA,
    SKIP
  } mdio_state_t;

  function automatic logic is_read_only(input logic [4:0] addr);
    return (addr == REG_PHYID1) || (addr == REG_PHYID2);
  endfunction

endpackage

// File: rtl/mdio_slave_if.sv
// MDIO pad and write-notify signals between the responder and its environment.
interface mdio_slave_if;
  logic        mdc;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_t;
  logic        busy;
  logic        wr_strobe;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;

  modport slave (
    input  mdc, mdio_i,
    output mdio_o, mdio_t, busy, wr_strobe, wr_addr, wr_data
  );

  modport master (
    output mdc, mdio_i,
    input  mdio_o, mdio_t, busy, wr_strobe, wr_addr, wr_data
  );
endinterface

// File: rtl/mdio_sync_edge.sv
// Two-flop synchronizer for an asynchronous pad input with a 0->1 detect.
// Resetting to 1 keeps a line that is already high from looking like a rise.
module mdio_sync_edge #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise
);
  logic r_meta;
  logic r_sync;
  logic r_sync_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta   <= RESET_VAL;
      r_sync   <= RESET_VAL;
      r_sync_d <= RESET_VAL;
    end else begin
      r_meta   <= i_async;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_sync_d;
endmodule

// File: rtl/mdio_slave.sv
// Clause-22 MDIO responder: decodes frames on synchronized MDC rises and
// serves a 32x16 register file (PHYID regs read-only) with a write notify.
module mdio_slave
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR      = 5'h01,
  parameter int          PREAMBLE_BITS = 32,
  parameter logic [15:0] PHYID1        = 16'h2000,
  parameter logic [15:0] PHYID2        = 16'h5C90,
  parameter logic [15:0] LEDCR_RESET   = 16'h0036
) (
  input logic         clk,
  input logic         reset_n,
  mdio_slave_if.slave bus
);
  localparam int               PRE_W   = (PREAMBLE_BITS < 1) ? 1 : $clog2(PREAMBLE_BITS + 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PREAMBLE_BITS);

  logic w_mdc_rise, w_mdc_sync_unused;
  logic w_mdio_bit, w_mdio_rise_unused;

  mdio_sync_edge u_sync_mdc (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (bus.mdc),
    .o_sync  (w_mdc_sync_unused),
    .o_rise  (w_mdc_rise)
  );

  mdio_sync_edge u_sync_mdio (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (bus.mdio_i),
    .o_sync  (w_mdio_bit),
    .o_rise  (w_mdio_rise_unused)
  );

  mdio_state_t      r_state, w_state_next;
  logic [4:0]       r_cnt, w_cnt_load;
  logic [PRE_W-1:0] r_pre_cnt;
  logic [15:0]      r_sreg;
  logic [15:0]      w_shift_in;
  logic [4:0]       r_regad;
  logic             r_is_read;
  logic             w_load_rd;
  logic [15:0]      w_rd_val;
  logic             w_commit;
  logic             w_mdio_o_next, w_mdio_t_next;

  logic             r_mdio_o, r_mdio_t, r_busy, r_wr_strobe;
  logic [4:0]       r_wr_addr;
  logic [15:0]      r_wr_data;

  assign w_shift_in = {r_sreg[14:0], w_mdio_bit};
  assign w_load_rd  = (r_state == TA) && r_is_read && (r_cnt == 5'd0);

  // Register file: PHYID regs are constants, everything else is plain storage.
  logic [15:0] w_reg_val [32];
  for (genvar gi = 0; gi < 32; gi++) begin : g_reg
    if (gi == int'(REG_PHYID1)) begin : g_id1
      assign w_reg_val[gi] = PHYID1;
    end else if (gi == int'(REG_PHYID2)) begin : g_id2
      assign w_reg_val[gi] = PHYID2;
    end else begin : g_rw
      localparam logic [15:0] RST_VAL = (gi == int'(REG_LEDCR)) ? LEDCR_RESET : 16'h0000;
      logic [15:0] r_val;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_val <= RST_VAL;
        end else if (w_commit && (r_regad == 5'(gi))) begin
          r_val <= w_shift_in;
        end
      end
      assign w_reg_val[gi] = r_val;
    end
  end

  assign w_rd_val = w_reg_val[r_regad];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_load   = 5'd0;
    if (w_mdc_rise) begin
      case (r_state)
        HUNT: if (!w_mdio_bit && (r_pre_cnt == PRE_MAX)) w_state_next = START;
        START: w_state_next = w_mdio_bit ? OP : HUNT;
        OP: if (r_cnt == 5'd1) begin
          w_state_next = ((w_shift_in[1:0] == OP_READ) || (w_shift_in[1:0] == OP_WRITE)) ? PHYAD : HUNT;
        end
        PHYAD: if (r_cnt == 5'd4) begin
          if (w_shift_in[4:0] == PHY_ADDR) begin
            w_state_next = REGAD;
          end else begin
            // 23 bits remain: REGAD, TA and data
            w_state_next = SKIP;
            w_cnt_load   = 5'd22;
          end
        end
        REGAD: if (r_cnt == 5'd4) w_state_next = TA;
        TA: begin
          if (r_is_read) begin
            if (r_cnt == 5'd1) w_state_next = RD_DATA;
          end else if (r_cnt == 5'd0) begin
            if (!w_mdio_bit) begin
              w_state_next = SKIP;
              w_cnt_load   = 5'd16;
            end
          end else if (w_mdio_bit) begin
            w_state_next = SKIP;
            w_cnt_load   = 5'd15;
          end else begin
            w_state_next = WR_DATA;
          end
        end
        RD_DATA, WR_DATA: if (r_cnt == 5'd15) w_state_next = HUNT;
        SKIP: if (r_cnt == 5'd0) w_state_next = HUNT;
        default: w_state_next = HUNT;
      endcase
    end
  end

  always_comb begin
    w_mdio_o_next = r_mdio_o;
    w_mdio_t_next = r_mdio_t;
    w_commit      = 1'b0;
    if (w_mdc_rise) begin
      case (r_state)
        TA: if (r_is_read) begin
          w_mdio_t_next = 1'b0;
          w_mdio_o_next = (r_cnt == 5'd0) ? 1'b0 : r_sreg[15];
        end
        RD_DATA: begin
          if (r_cnt == 5'd15) begin
            w_mdio_t_next = 1'b1;
            w_mdio_o_next = 1'b0;
          end else begin
            w_mdio_o_next = r_sreg[15];
          end
        end
        WR_DATA: w_commit = (r_cnt == 5'd15) && !is_read_only(r_regad);
        default: begin
          w_mdio_t_next = 1'b1;
          w_mdio_o_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= 5'd0;
      r_pre_cnt <= '0;
      r_sreg    <= 16'h0000;
      r_regad   <= 5'd0;
      r_is_read <= 1'b0;
    end else if (w_mdc_rise) begin
      r_sreg <= w_load_rd ? w_rd_val : w_shift_in;
      if (w_state_next != r_state) begin
        r_cnt <= w_cnt_load;
      end else if (r_state == SKIP) begin
        r_cnt <= r_cnt - 5'd1;
      end else begin
        r_cnt <= r_cnt + 5'd1;
      end
      if ((r_state == HUNT) && w_mdio_bit) begin
        if (r_pre_cnt != PRE_MAX) r_pre_cnt <= r_pre_cnt + PRE_W'(1);
      end else begin
        r_pre_cnt <= '0;
      end
      if ((r_state == OP) && (r_cnt == 5'd1)) r_is_read <= (w_shift_in[1:0] == OP_READ);
      if ((r_state == REGAD) && (r_cnt == 5'd4)) r_regad <= w_shift_in[4:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mdio_o    <= 1'b0;
      r_mdio_t    <= 1'b1;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= 5'd0;
      r_wr_data   <= 16'h0000;
    end else begin
      r_mdio_o    <= w_mdio_o_next;
      r_mdio_t    <= w_mdio_t_next;
      r_busy      <= (w_state_next != HUNT);
      r_wr_strobe <= w_commit;
      if (w_commit) begin
        r_wr_addr <= r_regad;
        r_wr_data <= w_shift_in;
      end
    end
  end

  assign bus.mdio_o    = r_mdio_o;
  assign bus.mdio_t    = r_mdio_t;
  assign bus.busy      = r_busy;
  assign bus.wr_strobe = r_wr_strobe;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
endmodule

// File: tb/tb_mdio_slave.sv
// Bench for mdio_slave: bit-banged MDIO master, table of frames, scoreboards
// for read data and write strobes, plus short-preamble and mid-read reset.
module tb_mdio_slave;
  import mdio_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic m_drv = 1'b1;
  always #5 clk = ~clk;

  mdio_slave_if bus ();
  assign bus.mdio_i = bus.mdio_t ? m_drv : bus.mdio_o;

  mdio_slave dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [4:0]  addr;
    logic [15:0] data;
  } wr_exp_t;

  wr_exp_t     wr_q [$];
  logic [15:0] rd_q [$];
  wr_exp_t     mon_e;

  always @(negedge clk) begin
    if (reset_n && bus.wr_strobe) begin
      if (wr_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: got addr %h data %h, required no strobe", bus.wr_addr, bus.wr_data);
      end else begin
        mon_e = wr_q.pop_front();
        check("strobe_addr", 32'(bus.wr_addr), 32'(mon_e.addr));
        check("strobe_data", 32'(bus.wr_data), 32'(mon_e.data));
      end
    end
  end

  task automatic mdc_bit(input logic b, output logic smp, output logic t_rise);
    m_drv   = b;
    bus.mdc = 1'b0;
    repeat (5) @(negedge clk);
    bus.mdc = 1'b1;
    smp     = bus.mdio_i;
    t_rise  = bus.mdio_t;
    repeat (5) @(negedge clk);
  endtask

  task automatic run_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                           input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] wd,
                           input int abort_at, output logic [15:0] rd, output int tlow,
                           output logic busy_mid);
    logic [31:0] fr;
    logic smp, t;
    repeat (pre) mdc_bit(1'b1, smp, t);
    fr = {2'b01, op, phy, ra, (op == OP_WRITE) ? ta : 2'b11, (op == OP_WRITE) ? wd : 16'hFFFF};
    rd = 16'hFFFF;
    tlow = 0;
    busy_mid = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      mdc_bit(fr[i], smp, t);
      if (!t) tlow++;
      if (i < 16) rd[i] = smp;
      if (i == 16) busy_mid = bus.busy;
      if (i == abort_at) return;
    end
    bus.mdc = 1'b0;
    m_drv   = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  ra;
    logic [1:0]  ta;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    int          exp_tlow;
    logic        exp_busy;
    logic        exp_strobe;
  } vec_t;

  localparam int NV = 22;
  vec_t        vecs [NV];
  vec_t        v;
  logic [15:0] rd;
  logic [15:0] exp_rd;
  int          tlow;
  logic        bm;

  initial begin
    vecs[0]  = '{OP_READ,  5'h01, 5'h18, 2'b10, 16'h0000, 16'h0036, 17, 1'b1, 1'b0};
    vecs[1]  = '{OP_WRITE, 5'h01, 5'h18, 2'b10, 16'hBEEF, 16'h0000,  0, 1'b1, 1'b1};
    vecs[2]  = '{OP_READ,  5'h01, 5'h18, 2'b10, 16'h0000, 16'hBEEF, 17, 1'b1, 1'b0};
    vecs[3]  = '{OP_READ,  5'h01, 5'h02, 2'b10, 16'h0000, 16'h2000, 17, 1'b1, 1'b0};
    vecs[4]  = '{OP_READ,  5'h01, 5'h03, 2'b10, 16'h0000, 16'h5C90, 17, 1'b1, 1'b0};
    vecs[5]  = '{OP_WRITE, 5'h01, 5'h02, 2'b10, 16'h1234, 16'h0000,  0, 1'b1, 1'b0};
    vecs[6]  = '{OP_READ,  5'h01, 5'h02, 2'b10, 16'h0000, 16'h2000, 17, 1'b1, 1'b0};
    vecs[7]  = '{OP_WRITE, 5'h01, 5'h03, 2'b10, 16'hFFFF, 16'h0000,  0, 1'b1, 1'b0};
    vecs[8]  = '{OP_READ,  5'h01, 5'h03, 2'b10, 16'h0000, 16'h5C90, 17, 1'b1, 1'b0};
    vecs[9]  = '{OP_READ,  5'h07, 5'h18, 2'b10, 16'h0000, 16'hFFFF,  0, 1'b1, 1'b0};
    vecs[10] = '{OP_WRITE, 5'h07, 5'h05, 2'b10, 16'hAAAA, 16'h0000,  0, 1'b1, 1'b0};
    vecs[11] = '{OP_READ,  5'h01, 5'h05, 2'b10, 16'h0000, 16'h0000, 17, 1'b1, 1'b0};
    vecs[12] = '{OP_WRITE, 5'h01, 5'h05, 2'b10, 16'h5A5A, 16'h0000,  0, 1'b1, 1'b1};
    vecs[13] = '{OP_WRITE, 5'h01, 5'h05, 2'b00, 16'h1111, 16'h0000,  0, 1'b1, 1'b0};
    vecs[14] = '{OP_WRITE, 5'h01, 5'h05, 2'b11, 16'h2222, 16'h0000,  0, 1'b1, 1'b0};
    vecs[15] = '{OP_READ,  5'h01, 5'h05, 2'b10, 16'h0000, 16'h5A5A, 17, 1'b1, 1'b0};
    vecs[16] = '{2'b00,    5'h01, 5'h05, 2'b10, 16'h0000, 16'hFFFF,  0, 1'b0, 1'b0};
    vecs[17] = '{2'b11,    5'h01, 5'h05, 2'b10, 16'h0000, 16'hFFFF,  0, 1'b0, 1'b0};
    vecs[18] = '{OP_WRITE, 5'h01, 5'h1F, 2'b10, 16'h8001, 16'h0000,  0, 1'b1, 1'b1};
    vecs[19] = '{OP_READ,  5'h01, 5'h1F, 2'b10, 16'h0000, 16'h8001, 17, 1'b1, 1'b0};
    vecs[20] = '{OP_READ,  5'h01, 5'h00, 2'b10, 16'h0000, 16'h0000, 17, 1'b1, 1'b0};
    vecs[21] = '{OP_READ,  5'h01, 5'h18, 2'b10, 16'h0000, 16'hBEEF, 17, 1'b1, 1'b0};

    bus.mdc = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mdio_t",    32'(bus.mdio_t),    32'd1);
    check("rst_mdio_o",    32'(bus.mdio_o),    32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_wr_strobe", 32'(bus.wr_strobe), 32'd0);
    check("rst_wr_addr",   32'(bus.wr_addr),   32'd0);
    check("rst_wr_data",   32'(bus.wr_data),   32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int k = 0; k < NV; k++) begin
      v = vecs[k];
      if (v.op != OP_WRITE) rd_q.push_back(v.exp_rd);
      if (v.exp_strobe) wr_q.push_back({v.ra, v.wdata});
      run_frame(32, v.op, v.phy, v.ra, v.ta, v.wdata, -1, rd, tlow, bm);
      $display("frame %0d op=%b phy=%h reg=%h ta=%b wdata=%h rdata=%h tlow=%0d busy_mid=%b",
               k, v.op, v.phy, v.ra, v.ta, v.wdata, rd, tlow, bm);
      if (v.op != OP_WRITE) begin
        exp_rd = rd_q.pop_front();
        check($sformatf("v%0d_rdata", k), 32'(rd), 32'(exp_rd));
      end
      check($sformatf("v%0d_tlow", k),     32'(tlow),            32'(v.exp_tlow));
      check($sformatf("v%0d_busy_mid", k), 32'(bm),              32'(v.exp_busy));
      check($sformatf("v%0d_busy_end", k), 32'(bus.busy),        32'd0);
      check($sformatf("v%0d_mdio_t", k),   32'(bus.mdio_t),      32'd1);
      check($sformatf("v%0d_wr_pend", k),  32'(wr_q.size()),     32'd0);
    end

    // 31-one preamble must be ignored; the next 32-one frame must succeed
    rd_q.push_back(16'hFFFF);
    run_frame(31, OP_READ, 5'h01, 5'h18, 2'b10, 16'h0000, -1, rd, tlow, bm);
    $display("short preamble read: rdata=%h tlow=%0d busy_mid=%b", rd, tlow, bm);
    exp_rd = rd_q.pop_front();
    check("short_pre_rdata", 32'(rd),   32'(exp_rd));
    check("short_pre_tlow",  32'(tlow), 32'd0);
    check("short_pre_busy",  32'(bm),   32'd0);
    rd_q.push_back(16'hBEEF);
    run_frame(32, OP_READ, 5'h01, 5'h18, 2'b10, 16'h0000, -1, rd, tlow, bm);
    $display("full preamble read: rdata=%h tlow=%0d", rd, tlow);
    exp_rd = rd_q.pop_front();
    check("full_pre_rdata", 32'(rd),   32'(exp_rd));
    check("full_pre_tlow",  32'(tlow), 32'd17);

    // reset asserted mid read-data must release the pad and reload the regs
    wr_q.push_back({5'h18, 16'hCAFE});
    run_frame(32, OP_WRITE, 5'h01, 5'h18, 2'b10, 16'hCAFE, -1, rd, tlow, bm);
    $display("write reg 18 data CAFE before abort");
    check("cafe_wr_pend", 32'(wr_q.size()), 32'd0);
    run_frame(32, OP_READ, 5'h01, 5'h18, 2'b10, 16'h0000, 8, rd, tlow, bm);
    check("abort_t_before", 32'(bus.mdio_t), 32'd0);
    reset_n = 1'b0;
    @(negedge clk);
    $display("reset asserted during read data bit 8");
    check("abort_mdio_t",  32'(bus.mdio_t),  32'd1);
    check("abort_busy",    32'(bus.busy),    32'd0);
    check("abort_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("abort_wr_data", 32'(bus.wr_data), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    bus.mdc = 1'b0;
    m_drv   = 1'b1;
    repeat (4) @(negedge clk);
    rd_q.push_back(16'h0036);
    rd_q.push_back(16'h0000);
    run_frame(32, OP_READ, 5'h01, 5'h18, 2'b10, 16'h0000, -1, rd, tlow, bm);
    $display("post-reset read reg 18: rdata=%h", rd);
    exp_rd = rd_q.pop_front();
    check("post_rst_ledcr", 32'(rd), 32'(exp_rd));
    run_frame(32, OP_READ, 5'h01, 5'h05, 2'b10, 16'h0000, -1, rd, tlow, bm);
    $display("post-reset read reg 05: rdata=%h", rd);
    exp_rd = rd_q.pop_front();
    check("post_rst_reg05", 32'(rd), 32'(exp_rd));
    check("final_wr_pend",  32'(wr_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
